// File: rtl/step_counter.sv
// rtl/step_counter.sv - registered up/down counter with programmable step, modulus and wrap/saturate
module step_counter #(
  parameter int WIDTH   = 4,
  parameter int MAX     = 2**WIDTH-1,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] count,
  output logic             ovf_p,
  output logic             at_bound,
  output logic             sticky
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MAX + 1);

  logic [WIDTH-1:0] step_x;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nxt_count;
  logic             nxt_ovf;

  always_comb begin
    // Clamping an out-of-range step keeps every wrap result inside 0..MAX.
    step_x    = (step > MAX_W) ? MAX_W : step;
    sum       = {1'b0, count} + {1'b0, step_x};
    nxt_count = count;
    nxt_ovf   = 1'b0;
    if (load) begin
      nxt_count = (load_val > MAX_W) ? MAX_W : load_val;
    end else if (en) begin
      if (up) begin
        if (sum > MAX_X) begin
          nxt_ovf   = 1'b1;
          nxt_count = sat ? MAX_W : WIDTH'(sum - MOD_X);
        end else begin
          nxt_count = sum[WIDTH-1:0];
        end
      end else begin
        if (step_x <= count) begin
          nxt_count = count - step_x;
        end else begin
          nxt_ovf   = 1'b1;
          nxt_count = sat ? '0 : WIDTH'({1'b0, count} + MOD_X - {1'b0, step_x});
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= RST_W;
      ovf_p  <= 1'b0;
      sticky <= 1'b0;
    end else begin
      count  <= nxt_count;
      ovf_p  <= nxt_ovf;
      sticky <= nxt_ovf | (sticky & ~clr_flag);
    end
  end

  assign at_bound = up ? (count == MAX_W) : (count == '0);

endmodule

// File: tb/tb_step_counter.sv
// tb/tb_step_counter.sv - randomized and directed check of step_counter against an arithmetic model
module tb_step_counter;

  localparam int W_A = 4;
  localparam int MAX_A = 15;
  localparam int W_B = 5;
  localparam int MAX_B = 19;

  typedef struct {
    bit rst, load, en, up, sat, clr;
    int lv, step;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           a_rst = 0, a_en = 0, a_up = 0, a_sat = 0, a_load = 0, a_clr = 0;
  logic [W_A-1:0] a_step = '0, a_lv = '0, a_count;
  logic           a_ovf, a_bound, a_sticky;
  logic           b_rst = 0, b_en = 0, b_up = 0, b_sat = 0, b_load = 0, b_clr = 0;
  logic [W_B-1:0] b_step = '0, b_lv = '0, b_count;
  logic           b_ovf, b_bound, b_sticky;

  step_counter #(.WIDTH(W_A), .MAX(MAX_A), .RST_VAL(0)) dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .up(a_up), .step(a_step), .sat(a_sat),
    .load(a_load), .load_val(a_lv), .clr_flag(a_clr),
    .count(a_count), .ovf_p(a_ovf), .at_bound(a_bound), .sticky(a_sticky)
  );

  step_counter #(.WIDTH(W_B), .MAX(MAX_B), .RST_VAL(0)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .up(b_up), .step(b_step), .sat(b_sat),
    .load(b_load), .load_val(b_lv), .clr_flag(b_clr),
    .count(b_count), .ovf_p(b_ovf), .at_bound(b_bound), .sticky(b_sticky)
  );

  always @(negedge clk) begin
    if (a_en && !a_load) assert (int'(a_step) <= MAX_A);
    if (b_en && !b_load) assert (int'(b_step) <= MAX_B);
  end

  int  total = 0;
  int  bad = 0;
  op_t op[2];
  int  m_cnt[2];
  int  m_ovf[2];
  int  m_sticky[2];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference behaviour straight from the counting rules, on plain integers.
  task automatic model(input int d);
    int mx, n;
    op_t o;
    o  = op[d];
    mx = (d == 0) ? MAX_A : MAX_B;
    if (o.rst) begin
      m_cnt[d] = 0; m_ovf[d] = 0; m_sticky[d] = 0;
      return;
    end
    m_ovf[d] = 0;
    if (o.load) begin
      m_cnt[d] = (o.lv > mx) ? mx : o.lv;
    end else if (o.en) begin
      n = o.up ? m_cnt[d] + o.step : m_cnt[d] - o.step;
      if (n > mx) begin
        m_ovf[d] = 1;
        m_cnt[d] = o.sat ? mx : n - (mx + 1);
      end else if (n < 0) begin
        m_ovf[d] = 1;
        m_cnt[d] = o.sat ? 0 : n + (mx + 1);
      end else begin
        m_cnt[d] = n;
      end
    end
    if (m_ovf[d] == 1) m_sticky[d] = 1;
    else if (o.clr) m_sticky[d] = 0;
  endtask

  task automatic cyc();
    int ea, eb;
    a_rst = op[0].rst; a_load = op[0].load; a_lv = W_A'(op[0].lv); a_en = op[0].en;
    a_up = op[0].up; a_step = W_A'(op[0].step); a_sat = op[0].sat; a_clr = op[0].clr;
    b_rst = op[1].rst; b_load = op[1].load; b_lv = W_B'(op[1].lv); b_en = op[1].en;
    b_up = op[1].up; b_step = W_B'(op[1].step); b_sat = op[1].sat; b_clr = op[1].clr;
    @(posedge clk);
    #1;
    model(0);
    model(1);
    ea = op[0].up ? int'(m_cnt[0] == MAX_A) : int'(m_cnt[0] == 0);
    eb = op[1].up ? int'(m_cnt[1] == MAX_B) : int'(m_cnt[1] == 0);
    chk("a_count", int'(a_count), m_cnt[0]);
    chk("a_ovf", int'(a_ovf), m_ovf[0]);
    chk("a_sticky", int'(a_sticky), m_sticky[0]);
    chk("a_bound", int'(a_bound), ea);
    chk("b_count", int'(b_count), m_cnt[1]);
    chk("b_ovf", int'(b_ovf), m_ovf[1]);
    chk("b_sticky", int'(b_sticky), m_sticky[1]);
    chk("b_bound", int'(b_bound), eb);
  endtask

  task automatic go(input int d, input bit rst, input bit load, input int lv, input bit en,
                    input bit up, input int step, input bit sat, input bit clr);
    op[0] = '{default: 0};
    op[1] = '{default: 0};
    op[d] = '{rst: rst, load: load, en: en, up: up, sat: sat, clr: clr, lv: lv, step: step};
    cyc();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      op[d] = '{default: 0};
      op[d].rst = 1;
    end
    cyc();

    // reset held with counting requested
    go(0, 1, 0, 0, 1, 1, 3, 0, 0);
    go(0, 1, 0, 0, 1, 1, 3, 0, 0);
    chk("rst_count", int'(a_count), 0);
    for (int i = 1; i <= 15; i++) begin
      go(0, 0, 0, 0, 1, 1, 1, 0, 0);
      chk("ramp_count", int'(a_count), i);
      chk("ramp_ovf", int'(a_ovf), 0);
    end
    chk("ramp_bound", int'(a_bound), 1);

    // wrap up then down
    go(0, 0, 1, 14, 0, 1, 0, 0, 0);
    go(0, 0, 0, 0, 1, 1, 3, 0, 0);
    chk("wrap_up", int'(a_count), 1);
    chk("wrap_up_ovf", int'(a_ovf), 1);
    chk("wrap_up_sticky", int'(a_sticky), 1);
    go(0, 0, 0, 0, 1, 0, 4, 0, 0);
    chk("wrap_dn", int'(a_count), 13);
    chk("wrap_dn_ovf", int'(a_ovf), 1);

    // saturate, including a step past an already-saturated bound
    go(0, 0, 1, 13, 0, 1, 0, 1, 0);
    go(0, 0, 0, 0, 1, 1, 5, 1, 0);
    chk("sat_up", int'(a_count), 15);
    go(0, 0, 0, 0, 1, 1, 5, 1, 0);
    chk("sat_again", int'(a_count), 15);
    chk("sat_again_ovf", int'(a_ovf), 1);
    go(0, 0, 1, 2, 0, 0, 0, 1, 0);
    go(0, 0, 0, 0, 1, 0, 7, 1, 0);
    chk("sat_dn", int'(a_count), 0);

    // priority and sticky interplay
    go(0, 0, 1, 7, 1, 1, 2, 0, 0);
    chk("load_prio", int'(a_count), 7);
    chk("load_ovf", int'(a_ovf), 0);
    go(0, 0, 1, 15, 0, 1, 0, 0, 0);
    go(0, 0, 0, 0, 1, 1, 1, 0, 1);
    chk("clr_vs_set", int'(a_sticky), 1);
    go(0, 0, 0, 0, 0, 1, 0, 0, 1);
    chk("clr_alone", int'(a_sticky), 0);

    // reset in the middle of counting
    go(0, 0, 1, 14, 0, 1, 0, 0, 0);
    go(0, 0, 0, 0, 1, 1, 11, 0, 0);
    chk("pre_rst_count", int'(a_count), 9);
    go(0, 1, 1, 5, 1, 1, 1, 0, 0);
    chk("mid_rst_count", int'(a_count), 0);
    chk("mid_rst_sticky", int'(a_sticky), 0);
    go(0, 0, 0, 0, 1, 1, 1, 0, 0);
    chk("resume", int'(a_count), 1);

    // non-power-of-two modulus
    go(1, 0, 1, 25, 0, 1, 0, 0, 0);
    chk("b_load_clamp", int'(b_count), 19);
    go(1, 0, 0, 0, 1, 1, 3, 0, 0);
    chk("b_wrap_up", int'(b_count), 2);
    go(1, 0, 0, 0, 1, 0, 5, 0, 0);
    chk("b_wrap_dn", int'(b_count), 17);

    // random traffic on both instances
    for (int n = 0; n < 600; n++) begin
      for (int d = 0; d < 2; d++) begin
        op[d].rst  = ($urandom_range(0, 49) == 0);
        op[d].load = ($urandom_range(0, 7) == 0);
        op[d].en   = ($urandom_range(0, 3) != 0);
        op[d].up   = $urandom_range(0, 1) == 1;
        op[d].sat  = $urandom_range(0, 1) == 1;
        op[d].clr  = ($urandom_range(0, 9) == 0);
        op[d].step = (d == 0) ? $urandom_range(0, MAX_A) : $urandom_range(0, MAX_B);
        op[d].lv   = (d == 0) ? $urandom_range(0, 15) : $urandom_range(0, 31);
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
